// File: rtl/amber_dmem_arb.sv
// Shares the single-port amber data memory between the core MA stage and the debug/loader port.
// Core has priority unless the core is halted or debug has lost MAX_WAIT times in a row.
module amber_dmem_arb #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 24,
    parameter int MAX_WAIT = 4
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic              iw_halt,
    input  logic              iw_c_req,
    input  logic              iw_c_we,
    input  logic [ADDR_W-1:0] iw_c_addr,
    input  logic [DATA_W-1:0] iw_c_wdata,
    output logic              ow_c_stall,
    output logic              ow_c_rvalid,
    output logic [DATA_W-1:0] ow_c_rdata,
    input  logic              iw_d_req,
    input  logic              iw_d_we,
    input  logic [ADDR_W-1:0] iw_d_addr,
    input  logic [DATA_W-1:0] iw_d_wdata,
    output logic              ow_d_gnt,
    output logic              ow_d_rvalid,
    output logic [DATA_W-1:0] ow_d_rdata,
    output logic              ow_m_en,
    output logic              ow_m_we,
    output logic [ADDR_W-1:0] ow_m_addr,
    output logic [DATA_W-1:0] ow_m_wdata,
    input  logic [DATA_W-1:0] iw_m_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } own_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0]        r_wait;
    logic [3:0]        wait_nxt;
    own_t              r_rd_own;
    own_t              own_nxt;
    logic [DATA_W-1:0] r_c_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              debug_win;
    logic              core_win;

    // Grants are gated by reset so the memory stays idle while rst is low.
    always_comb begin
        debug_win = iw_rst & iw_d_req & (iw_halt | (r_wait == WAIT_LIMIT) | ~iw_c_req);
        core_win  = iw_rst & iw_c_req & ~debug_win;

        ow_m_en    = 1'b0;
        ow_m_we    = 1'b0;
        ow_m_addr  = '0;
        ow_m_wdata = '0;
        own_nxt    = OWN_NONE;
        if (debug_win) begin
            ow_m_en    = 1'b1;
            ow_m_we    = iw_d_we;
            ow_m_addr  = iw_d_addr;
            ow_m_wdata = iw_d_wdata;
            if (!iw_d_we) own_nxt = OWN_DBG;
        end else if (core_win) begin
            ow_m_en    = 1'b1;
            ow_m_we    = iw_c_we;
            ow_m_addr  = iw_c_addr;
            ow_m_wdata = iw_c_wdata;
            if (!iw_c_we) own_nxt = OWN_CORE;
        end

        wait_nxt = r_wait;
        if (debug_win || !iw_d_req) begin
            wait_nxt = 4'd0;
        end else if (core_win && (r_wait < WAIT_LIMIT)) begin
            wait_nxt = r_wait + 4'd1;
        end

        ow_c_stall = iw_rst & iw_c_req & ~core_win;
        ow_d_gnt   = debug_win;
    end

    always_ff @(posedge iw_clk or negedge iw_rst) begin
        if (!iw_rst) begin
            r_wait    <= 4'd0;
            r_rd_own  <= OWN_NONE;
            r_c_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_wait   <= wait_nxt;
            r_rd_own <= own_nxt;
            if (r_rd_own == OWN_CORE) r_c_rdata <= iw_m_rdata;
            if (r_rd_own == OWN_DBG)  r_d_rdata <= iw_m_rdata;
        end
    end

    // Read data arrives one cycle after the grant; the owner sees it live, the other port holds its last word.
    assign ow_c_rvalid = (r_rd_own == OWN_CORE);
    assign ow_d_rvalid = (r_rd_own == OWN_DBG);
    assign ow_c_rdata  = ow_c_rvalid ? iw_m_rdata : r_c_rdata;
    assign ow_d_rdata  = ow_d_rvalid ? iw_m_rdata : r_d_rdata;

endmodule

// File: tb/tb_amber_dmem_arb.sv
// Directed bench for amber_dmem_arb with a one-cycle-latency behavioural data memory.
module tb_amber_dmem_arb;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 24;

    logic              iw_clk = 1'b0;
    logic              iw_rst = 1'b0;
    logic              iw_halt = 1'b0;
    logic              iw_c_req = 1'b0;
    logic              iw_c_we = 1'b0;
    logic [ADDR_W-1:0] iw_c_addr = '0;
    logic [DATA_W-1:0] iw_c_wdata = '0;
    logic              ow_c_stall;
    logic              ow_c_rvalid;
    logic [DATA_W-1:0] ow_c_rdata;
    logic              iw_d_req = 1'b0;
    logic              iw_d_we = 1'b0;
    logic [ADDR_W-1:0] iw_d_addr = '0;
    logic [DATA_W-1:0] iw_d_wdata = '0;
    logic              ow_d_gnt;
    logic              ow_d_rvalid;
    logic [DATA_W-1:0] ow_d_rdata;
    logic              ow_m_en;
    logic              ow_m_we;
    logic [ADDR_W-1:0] ow_m_addr;
    logic [DATA_W-1:0] ow_m_wdata;
    logic [DATA_W-1:0] iw_m_rdata = '0;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int tests_run = 0;
    int fails = 0;

    amber_dmem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
        .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_halt(iw_halt),
        .iw_c_req(iw_c_req), .iw_c_we(iw_c_we), .iw_c_addr(iw_c_addr), .iw_c_wdata(iw_c_wdata),
        .ow_c_stall(ow_c_stall), .ow_c_rvalid(ow_c_rvalid), .ow_c_rdata(ow_c_rdata),
        .iw_d_req(iw_d_req), .iw_d_we(iw_d_we), .iw_d_addr(iw_d_addr), .iw_d_wdata(iw_d_wdata),
        .ow_d_gnt(ow_d_gnt), .ow_d_rvalid(ow_d_rvalid), .ow_d_rdata(ow_d_rdata),
        .ow_m_en(ow_m_en), .ow_m_we(ow_m_we), .ow_m_addr(ow_m_addr), .ow_m_wdata(ow_m_wdata),
        .iw_m_rdata(iw_m_rdata)
    );

    always #5 iw_clk = ~iw_clk;

    always @(posedge iw_clk) begin
        if (ow_m_en) begin
            if (ow_m_we) mem[ow_m_addr] <= ow_m_wdata;
            else         iw_m_rdata <= mem[ow_m_addr];
        end
    end

    task automatic next_cycle();
        @(posedge iw_clk);
        #1;
    endtask

    task automatic test_reset();
        iw_c_req = 1'b1;
        iw_d_req = 1'b1;
        #3;
        tests_run++; if (ow_m_en !== 1'b0) begin fails++; $display("FAIL reset_m_en got %0h want 0", ow_m_en); end
        tests_run++; if (ow_c_stall !== 1'b0 || ow_d_gnt !== 1'b0) begin fails++; $display("FAIL reset_stall_gnt got %0h/%0h want 0/0", ow_c_stall, ow_d_gnt); end
        tests_run++; if (ow_c_rvalid !== 1'b0 || ow_d_rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid got %0h/%0h want 0/0", ow_c_rvalid, ow_d_rvalid); end
        tests_run++; if (ow_c_rdata !== 24'h0 || ow_d_rdata !== 24'h0) begin fails++; $display("FAIL reset_rdata got %0h/%0h want 0/0", ow_c_rdata, ow_d_rdata); end
        iw_c_req = 1'b0;
        iw_d_req = 1'b0;
        next_cycle();
        iw_rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_core_only();
        iw_c_req = 1'b1; iw_c_we = 1'b0; iw_c_addr = 12'h001;
        #1;
        tests_run++; if (ow_c_stall !== 1'b0 || ow_m_en !== 1'b1 || ow_m_addr !== 12'h001) begin fails++; $display("FAIL core_rd1_issue got stall=%0h en=%0h addr=%0h want 0/1/001", ow_c_stall, ow_m_en, ow_m_addr); end
        next_cycle();
        iw_c_addr = 12'h002;
        #1;
        tests_run++; if (ow_c_rvalid !== 1'b1 || ow_c_rdata !== 24'h301000) begin fails++; $display("FAIL core_rd1_data got v=%0h d=%0h want 1/301000", ow_c_rvalid, ow_c_rdata); end
        tests_run++; if (ow_c_stall !== 1'b0 || ow_d_rvalid !== 1'b0) begin fails++; $display("FAIL core_rd2_issue got stall=%0h dv=%0h want 0/0", ow_c_stall, ow_d_rvalid); end
        next_cycle();
        iw_c_req = 1'b0;
        #1;
        tests_run++; if (ow_c_rvalid !== 1'b1 || ow_c_rdata !== 24'h721003) begin fails++; $display("FAIL core_rd2_data got v=%0h d=%0h want 1/721003", ow_c_rvalid, ow_c_rdata); end
        tests_run++; if (ow_m_en !== 1'b0 || ow_d_rvalid !== 1'b0) begin fails++; $display("FAIL core_idle got en=%0h dv=%0h want 0/0", ow_m_en, ow_d_rvalid); end
        next_cycle();
        #1;
        tests_run++; if (ow_c_rvalid !== 1'b0 || ow_c_rdata !== 24'h721003) begin fails++; $display("FAIL core_hold got v=%0h d=%0h want 0/721003", ow_c_rvalid, ow_c_rdata); end
    endtask

    task automatic test_debug_only();
        next_cycle();
        iw_d_req = 1'b1; iw_d_we = 1'b1; iw_d_addr = 12'hFFF; iw_d_wdata = 24'hA00000;
        #1;
        tests_run++; if (ow_d_gnt !== 1'b1 || ow_m_we !== 1'b1 || ow_m_addr !== 12'hFFF || ow_m_wdata !== 24'hA00000) begin fails++; $display("FAIL dbg_wr got gnt=%0h we=%0h addr=%0h wd=%0h want 1/1/fff/a00000", ow_d_gnt, ow_m_we, ow_m_addr, ow_m_wdata); end
        next_cycle();
        iw_d_we = 1'b0;
        #1;
        tests_run++; if (ow_d_gnt !== 1'b1 || ow_d_rvalid !== 1'b0) begin fails++; $display("FAIL dbg_rd_issue got gnt=%0h dv=%0h want 1/0", ow_d_gnt, ow_d_rvalid); end
        next_cycle();
        iw_d_req = 1'b0;
        #1;
        tests_run++; if (ow_d_rvalid !== 1'b1 || ow_d_rdata !== 24'hA00000 || ow_c_rvalid !== 1'b0) begin fails++; $display("FAIL dbg_rd_data got v=%0h d=%0h cv=%0h want 1/a00000/0", ow_d_rvalid, ow_d_rdata, ow_c_rvalid); end
    endtask

    task automatic test_contention();
        logic exp;
        next_cycle();
        iw_c_req = 1'b1; iw_c_we = 1'b0; iw_c_addr = 12'h003;
        iw_d_req = 1'b1; iw_d_we = 1'b0; iw_d_addr = 12'h004;
        for (int i = 0; i < 10; i++) begin
            exp = (i == 4) || (i == 9);
            #1;
            tests_run++; if (ow_d_gnt !== exp || ow_c_stall !== exp) begin fails++; $display("FAIL contention_c%0d got gnt=%0h stall=%0h want %0h/%0h", i, ow_d_gnt, ow_c_stall, exp, exp); end
            next_cycle();
        end
        iw_c_req = 1'b0;
        iw_d_req = 1'b0;
    endtask

    task automatic test_halt();
        next_cycle();
        iw_c_req = 1'b1; iw_d_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            iw_halt = (i >= 2) && (i < 6);
            #1;
            tests_run++; if (ow_d_gnt !== iw_halt || ow_c_stall !== iw_halt) begin fails++; $display("FAIL halt_c%0d got gnt=%0h stall=%0h want %0h/%0h", i, ow_d_gnt, ow_c_stall, iw_halt, iw_halt); end
            next_cycle();
        end
        // After halt the counter restarts: 4 losses (two already at cycles 6,7), then a win.
        iw_halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++; if (ow_d_gnt !== (i == 2)) begin fails++; $display("FAIL post_halt_c%0d got gnt=%0h want %0h", i, ow_d_gnt, (i == 2)); end
            next_cycle();
        end
        iw_c_req = 1'b0; iw_d_req = 1'b0;
    endtask

    task automatic test_withdraw();
        next_cycle();
        iw_c_req = 1'b1; iw_c_addr = 12'h055;
        iw_d_req = 1'b1; iw_d_addr = 12'h066;
        next_cycle();
        next_cycle();
        iw_d_req = 1'b0;
        #1;
        tests_run++; if (ow_d_gnt !== 1'b0 || ow_m_addr !== 12'h055) begin fails++; $display("FAIL withdraw got gnt=%0h addr=%0h want 0/055", ow_d_gnt, ow_m_addr); end
        next_cycle();
        iw_d_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++; if (ow_d_gnt !== (i == 4)) begin fails++; $display("FAIL rerequest_c%0d got gnt=%0h want %0h", i, ow_d_gnt, (i == 4)); end
            next_cycle();
        end
        iw_c_req = 1'b0; iw_d_req = 1'b0;
    endtask

    task automatic test_read_routing();
        next_cycle();
        iw_c_req = 1'b1; iw_c_we = 1'b0; iw_c_addr = 12'h010;
        next_cycle();
        iw_c_req = 1'b0;
        iw_d_req = 1'b1; iw_d_we = 1'b0; iw_d_addr = 12'h020;
        #1;
        tests_run++; if (ow_c_rvalid !== 1'b1 || ow_c_rdata !== 24'h123456 || ow_d_rvalid !== 1'b0) begin fails++; $display("FAIL route_core got cv=%0h cd=%0h dv=%0h want 1/123456/0", ow_c_rvalid, ow_c_rdata, ow_d_rvalid); end
        next_cycle();
        iw_d_req = 1'b0;
        #1;
        tests_run++; if (ow_d_rvalid !== 1'b1 || ow_d_rdata !== 24'h654321 || ow_c_rvalid !== 1'b0) begin fails++; $display("FAIL route_dbg got dv=%0h dd=%0h cv=%0h want 1/654321/0", ow_d_rvalid, ow_d_rdata, ow_c_rvalid); end
        tests_run++; if (ow_c_rdata !== 24'h123456) begin fails++; $display("FAIL route_core_hold got %0h want 123456", ow_c_rdata); end
    endtask

    task automatic test_reset_mid_read();
        next_cycle();
        iw_c_req = 1'b1; iw_c_we = 1'b0; iw_c_addr = 12'h001;
        @(posedge iw_clk);
        #2;
        iw_rst = 1'b0;
        #1;
        tests_run++; if (ow_c_rvalid !== 1'b0 || ow_d_rvalid !== 1'b0) begin fails++; $display("FAIL rst_mid_rvalid got %0h/%0h want 0/0", ow_c_rvalid, ow_d_rvalid); end
        tests_run++; if (ow_m_en !== 1'b0 || ow_c_stall !== 1'b0) begin fails++; $display("FAIL rst_mid_port got en=%0h stall=%0h want 0/0", ow_m_en, ow_c_stall); end
        iw_c_req = 1'b0;
        next_cycle();
        iw_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests_run++; if (ow_c_rvalid !== 1'b0 || ow_c_rdata !== 24'h0) begin fails++; $display("FAIL rst_release_c%0d got v=%0h d=%0h want 0/0", i, ow_c_rvalid, ow_c_rdata); end
            next_cycle();
        end
    endtask

    initial begin
        mem[12'h001] = 24'h301000;
        mem[12'h002] = 24'h721003;
        mem[12'h010] = 24'h123456;
        mem[12'h020] = 24'h654321;
        test_reset();
        test_core_only();
        test_debug_only();
        test_contention();
        test_halt();
        test_withdraw();
        test_read_routing();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/amber_dmem_arb.md
Name: amber_dmem_arb

Overview:
Arbiter sharing the single-port amber data memory between the core's memory-access (MA) stage and an external debug/loader port. The core has priority by default. A starvation counter guarantees the debug port a slot. The arbiter drives the memory port combinationally from the current grant, tracks which requester owns each outstanding read, and routes the one-cycle-latency read data back to that requester.

Parameters:
ADDR_W, 12, data memory word-address width (4096 words)
DATA_W, 24, memory word width
MAX_WAIT, 4, consecutive debug losses after which debug is forced to win (1..15)

Ports:
iw_clk  in  1  clock, rising edge
iw_rst  in  1  reset, asynchronous, active-low
iw_halt  in  1  core halted (SRHLT retired); debug gets priority
iw_c_req  in  1  core MA-stage access request
iw_c_we  in  1  core write enable
iw_c_addr  in  ADDR_W  core address
iw_c_wdata  in  DATA_W  core write data
ow_c_stall  out  1  core request not granted this cycle; pipeline must hold
ow_c_rvalid  out  1  core read data valid
ow_c_rdata  out  DATA_W  core read data
iw_d_req  in  1  debug access request; held until granted
iw_d_we  in  1  debug write enable
iw_d_addr  in  ADDR_W  debug address
iw_d_wdata  in  DATA_W  debug write data
ow_d_gnt  out  1  debug request accepted this cycle
ow_d_rvalid  out  1  debug read data valid
ow_d_rdata  out  DATA_W  debug read data
ow_m_en  out  1  memory enable
ow_m_we  out  1  memory write enable
ow_m_addr  out  ADDR_W  memory address
ow_m_wdata  out  DATA_W  memory write data
iw_m_rdata  in  DATA_W  memory read data, valid 1 cycle after a read enable

Behaviour:
- Reset (iw_rst=0, asynchronous): r_wait=0, r_rd_own=NONE, ow_c_rvalid=0, ow_d_rvalid=0, ow_c_rdata=0, ow_d_rdata=0. Combinational outputs during reset: ow_m_en=0, ow_c_stall=0, ow_d_gnt=0.
- Grant (combinational, each cycle):
  - Debug wins if iw_d_req and (iw_halt or r_wait==MAX_WAIT or !iw_c_req).
  - Otherwise core wins if iw_c_req.
  - Otherwise no grant.
- Memory port mirrors the winner's we/addr/wdata with ow_m_en=1. With no winner: ow_m_en=0, ow_m_we=0, addr/wdata=0.
- ow_c_stall = iw_c_req & !core_win. ow_d_gnt = debug_win.
- Starvation counter r_wait:
  - Increments when iw_d_req and core wins (saturates at MAX_WAIT).
  - Cleared when debug wins or iw_d_req=0.
- Read tracking, registered:
  - r_rd_own <= CORE / DBG on a granted read (we=0), else NONE.
  - Next cycle: the owner's rvalid=1 and its rdata captures iw_m_rdata. The other port's rvalid=0 and its rdata holds its last value.
  - Writes produce no rvalid.
- Latency: grant at cycle N, memory access at the cycle-N edge, rvalid/rdata at cycle N+1. Back-to-back reads from either port are sustained at one per cycle.
- Simultaneous requests with core priority: core served, debug waits. After MAX_WAIT consecutive losses, debug is served for exactly one cycle, during which core stalls. The counter then restarts from 0.
- A core write and a debug write to the same address cannot collide: only one is granted per cycle.
- iw_halt asserted mid-wait: debug is granted in the same cycle.
- Reset mid-read: the pending rvalid is dropped and never asserted after reset release.
- Debug deasserting iw_d_req before grant is legal. The counter clears and no access occurs.

Test Plan:
- Core only: reads at addr 0x001, 0x002 on consecutive cycles with mem[1]=0x301000, mem[2]=0x721003 -> no stall; ow_c_rvalid high at N+1 and N+2 with those values; ow_d_rvalid stays 0.
- Debug only: write 0xA00000 to 0xFFF, then read 0xFFF -> ow_d_gnt=1 on both cycles; ow_d_rvalid=1 with ow_d_rdata=0xA00000 one cycle after the read.
- Contention, MAX_WAIT=4: core and debug both request continuously -> core granted cycles 0-3, debug granted cycle 4 with ow_c_stall=1 that cycle, core granted cycles 5-8, debug cycle 9.
- Halt: iw_halt=1 with both requesting -> ow_d_gnt=1 every cycle, ow_c_stall=1, r_wait stays 0.
- Read routing: core read 0x010 at cycle N, debug read 0x020 at cycle N+1 -> ow_c_rvalid only at N+1 carrying mem[0x010]; ow_d_rvalid only at N+2 carrying mem[0x020].
- Reset mid-read: core read granted, iw_rst driven low 2 ns later -> rvalids 0 immediately and stay 0 after release; ow_m_en=0 while in reset.
